// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the two-master AHB-lite arbiter.
// The address-phase struct carries up to ARB_ADDR_W address bits.
package ahb_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StHeld,
    StAph,
    StDph
  } port_state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnIm,
    OwnDm
  } owner_e;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  write;
    logic [3:0]            prot;
  } aph_t;

  function automatic logic is_req(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_arb_port.sv
// Per-master front end: one-entry hold register, request FSM and the
// master-facing hready. Instantiated once per master by ahb_bus_arbiter.
module ahb_arb_port
  import ahb_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_htrans,
  input  aph_t       i_aph,
  input  logic       i_bus_hready,
  input  logic       i_grant,
  output logic       o_hready,
  output logic       o_held,
  output logic       o_in_aph,
  output aph_t       o_hold
);

  port_state_e r_state;
  aph_t        r_hold;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_hold  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Capture is independent of the bus hready: the master sees hready_x=1 here.
          if (is_req(i_htrans)) begin
            r_hold  <= i_aph;
            r_state <= StHeld;
          end
        end
        StHeld: begin
          if (i_bus_hready && i_grant) r_state <= StAph;
        end
        StAph: begin
          if (i_bus_hready) r_state <= StDph;
        end
        StDph: begin
          if (i_bus_hready) begin
            if (is_req(i_htrans)) begin
              r_hold  <= i_aph;
              r_state <= StHeld;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_hready = 1'b0;
    unique case (r_state)
      StIdle:  o_hready = 1'b1;
      StDph:   o_hready = i_bus_hready;
      default: o_hready = 1'b0;
    endcase
  end

  assign o_held   = (r_state == StHeld);
  assign o_in_aph = (r_state == StAph);
  assign o_hold   = r_hold;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Two-master (IM/DM) to one-slave AHB-lite arbiter with registered address phase.
// Optional: define ARB_PERF_CNT_EN for grant/contention counters. ADDR_W must be <= 32.
module ahb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DM_PRIORITY = 1
`ifdef ARB_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W       = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] im_haddr,
  input  logic [1:0]        im_htrans,
  input  logic              im_hwrite,
  input  logic [3:0]        im_hprot,
  input  logic [DATA_W-1:0] im_hwdata,
  output logic              im_hready,
  output logic              im_hresp,
  output logic [DATA_W-1:0] im_hrdata,
  input  logic [ADDR_W-1:0] dm_haddr,
  input  logic [1:0]        dm_htrans,
  input  logic              dm_hwrite,
  input  logic [3:0]        dm_hprot,
  input  logic [DATA_W-1:0] dm_hwdata,
  output logic              dm_hready,
  output logic              dm_hresp,
  output logic [DATA_W-1:0] dm_hrdata,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [3:0]        hprot,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  im_grant_cnt,
  output logic [CNT_W-1:0]  dm_grant_cnt,
  output logic [CNT_W-1:0]  contention_cnt
`endif
);

  aph_t       w_im_aph, w_dm_aph, w_im_hold, w_dm_hold;
  aph_t       r_bus_aph;
  logic [1:0] r_htrans;
  owner_e     r_owner;
  logic       w_im_held, w_dm_held, w_im_in_aph, w_dm_in_aph;
  logic       w_im_grant, w_dm_grant;
  logic       w_unused_htrans;

  assign w_im_aph = '{addr: ARB_ADDR_W'(im_haddr), write: im_hwrite, prot: im_hprot};
  assign w_dm_aph = '{addr: ARB_ADDR_W'(dm_haddr), write: dm_hwrite, prot: dm_hprot};

  // SEQ vs NONSEQ is irrelevant: every launch is issued as NONSEQ.
  assign w_unused_htrans = ^{im_htrans[0], dm_htrans[0]};

  ahb_arb_port u_im_port (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_htrans     (im_htrans),
    .i_aph        (w_im_aph),
    .i_bus_hready (hready),
    .i_grant      (w_im_grant),
    .o_hready     (im_hready),
    .o_held       (w_im_held),
    .o_in_aph     (w_im_in_aph),
    .o_hold       (w_im_hold)
  );

  ahb_arb_port u_dm_port (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_htrans     (dm_htrans),
    .i_aph        (w_dm_aph),
    .i_bus_hready (hready),
    .i_grant      (w_dm_grant),
    .o_hready     (dm_hready),
    .o_held       (w_dm_held),
    .o_in_aph     (w_dm_in_aph),
    .o_hold       (w_dm_hold)
  );

  assign w_dm_grant = w_dm_held && (!w_im_held || (DM_PRIORITY != 0));
  assign w_im_grant = w_im_held && (!w_dm_held || (DM_PRIORITY == 0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_aph <= '0;
      r_htrans  <= HTRANS_IDLE;
      r_owner   <= OwnNone;
    end else if (hready) begin
      if (w_dm_grant) begin
        r_bus_aph <= w_dm_hold;
        r_htrans  <= HTRANS_NONSEQ;
      end else if (w_im_grant) begin
        r_bus_aph <= w_im_hold;
        r_htrans  <= HTRANS_NONSEQ;
      end else begin
        r_htrans  <= HTRANS_IDLE;
      end
      r_owner <= w_im_in_aph ? OwnIm : (w_dm_in_aph ? OwnDm : OwnNone);
    end
  end

  assign haddr  = r_bus_aph.addr[ADDR_W-1:0];
  assign htrans = r_htrans;
  assign hwrite = r_bus_aph.write;
  assign hprot  = r_bus_aph.prot;

  always_comb begin
    hwdata   = '0;
    im_hresp = 1'b0;
    dm_hresp = 1'b0;
    unique case (r_owner)
      OwnIm: begin
        hwdata   = im_hwdata;
        im_hresp = hresp;
      end
      OwnDm: begin
        hwdata   = dm_hwdata;
        dm_hresp = hresp;
      end
      default: hwdata = '0;
    endcase
  end

  assign im_hrdata = hrdata;
  assign dm_hrdata = hrdata;

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] r_im_grant_cnt, r_dm_grant_cnt, r_contention_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_im_grant_cnt   <= '0;
      r_dm_grant_cnt   <= '0;
      r_contention_cnt <= '0;
    end else begin
      if (hready && w_im_grant) r_im_grant_cnt <= r_im_grant_cnt + CNT_W'(1);
      if (hready && w_dm_grant) r_dm_grant_cnt <= r_dm_grant_cnt + CNT_W'(1);
      if (w_im_held && w_dm_held) r_contention_cnt <= r_contention_cnt + CNT_W'(1);
    end
  end

  assign im_grant_cnt   = r_im_grant_cnt;
  assign dm_grant_cnt   = r_dm_grant_cnt;
  assign contention_cnt = r_contention_cnt;
`endif

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed latency/contention/stall/error/reset
// scenarios, then random traffic against a transaction-level model. Honors ARB_PERF_CNT_EN.
`timescale 1ns/1ps
module tb_ahb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] im_haddr, dm_haddr, haddr, im_hwdata, dm_hwdata, hwdata;
  logic [31:0] im_hrdata, dm_hrdata, hrdata;
  logic [1:0]  im_htrans, dm_htrans, htrans;
  logic        im_hwrite, dm_hwrite, hwrite;
  logic [3:0]  im_hprot, dm_hprot, hprot;
  logic        im_hready, dm_hready, im_hresp, dm_hresp, hready, hresp;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] im_grant_cnt, dm_grant_cnt, contention_cnt;
`endif

  always #5 clk = ~clk;

  ahb_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .im_haddr  (im_haddr),
    .im_htrans (im_htrans),
    .im_hwrite (im_hwrite),
    .im_hprot  (im_hprot),
    .im_hwdata (im_hwdata),
    .im_hready (im_hready),
    .im_hresp  (im_hresp),
    .im_hrdata (im_hrdata),
    .dm_haddr  (dm_haddr),
    .dm_htrans (dm_htrans),
    .dm_hwrite (dm_hwrite),
    .dm_hprot  (dm_hprot),
    .dm_hwdata (dm_hwdata),
    .dm_hready (dm_hready),
    .dm_hresp  (dm_hresp),
    .dm_hrdata (dm_hrdata),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hprot     (hprot),
    .hwdata    (hwdata),
    .hready    (hready),
    .hresp     (hresp),
    .hrdata    (hrdata)
`ifdef ARB_PERF_CNT_EN
    ,
    .im_grant_cnt   (im_grant_cnt),
    .dm_grant_cnt   (dm_grant_cnt),
    .contention_cnt (contention_cnt)
`endif
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    im_htrans = 2'b00; im_haddr = '0; im_hwrite = 1'b0; im_hprot = '0;
    dm_htrans = 2'b00; dm_haddr = '0; dm_hwrite = 1'b0; dm_hprot = '0;
  endtask

  // IM read 0xA000_0000 and DM write 0xB000_0004 in the same cycle; optional 2-cycle stall.
  task automatic run_contention(input bit stall);
    cyc();
    hready = 1'b1; hresp = 1'b0;
    im_htrans = 2'b10; im_haddr = 32'hA000_0000; im_hwrite = 1'b0; im_hwdata = '0;
    dm_htrans = 2'b10; dm_haddr = 32'hB000_0004; dm_hwrite = 1'b1;
    dm_hwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("cont_c0_im_hready", im_hready, 1);
    cyc(); idle_masters();
    @(negedge clk);
    chk("cont_c1_im_hready", im_hready, 0);
    chk("cont_c1_dm_hready", dm_hready, 0);
    cyc();
    @(negedge clk);
    chk("cont_c2_haddr", haddr, 32'hB000_0004);
    chk("cont_c2_htrans", htrans, 2'b10);
    chk("cont_c2_hwrite", hwrite, 1);
    cyc();
    hready = !stall;
    @(negedge clk);
    chk("cont_c3_haddr", haddr, 32'hA000_0000);
    chk("cont_c3_htrans", htrans, 2'b10);
    chk("cont_c3_hwrite", hwrite, 0);
    chk("cont_c3_hwdata", hwdata, 32'hDEAD_BEEF);
    chk("cont_c3_dm_hready", dm_hready, !stall);
    chk("cont_c3_im_hready", im_hready, 0);
    if (stall) begin
      cyc();
      @(negedge clk);
      chk("stall_c4_dm_hready", dm_hready, 0);
      chk("stall_c4_haddr", haddr, 32'hA000_0000);
      chk("stall_c4_htrans", htrans, 2'b10);
      chk("stall_c4_im_hready", im_hready, 0);
      cyc();
      hready = 1'b1;
      @(negedge clk);
      chk("stall_c5_dm_hready", dm_hready, 1);
      chk("stall_c5_haddr", haddr, 32'hA000_0000);
      chk("stall_c5_im_hready", im_hready, 0);
    end
    cyc();
    hrdata = 32'hC0FF_EE00;
    @(negedge clk);
    chk("cont_im_done_hready", im_hready, 1);
    chk("cont_im_done_hrdata", im_hrdata, 32'hC0FF_EE00);
    chk("cont_im_done_htrans", htrans, 2'b00);
    cyc();
    @(negedge clk);
    chk("cont_end_im_hready", im_hready, 1);
    chk("cont_end_dm_hready", dm_hready, 1);
  endtask

  // Single IM read of 0xA000_0010; with err, slave errors it while a DM write follows.
  task automatic run_im_read(input bit err);
    cyc();
    im_htrans = 2'b10; im_haddr = 32'hA000_0010; im_hwrite = 1'b0; im_hprot = 4'h3;
    @(negedge clk);
    chk("rd_c0_im_hready", im_hready, 1);
    cyc(); idle_masters();
    if (err) begin
      dm_htrans = 2'b10; dm_haddr = 32'hB000_0020; dm_hwrite = 1'b1;
      dm_hwdata = 32'h5A5A_5A5A;
    end
    @(negedge clk);
    chk("rd_c1_im_hready", im_hready, 0);
    cyc(); idle_masters();
    @(negedge clk);
    chk("rd_c2_haddr", haddr, 32'hA000_0010);
    chk("rd_c2_htrans", htrans, 2'b10);
    chk("rd_c2_hwrite", hwrite, 0);
    chk("rd_c2_hprot", hprot, 4'h3);
    chk("rd_c2_im_hready", im_hready, 0);
    cyc();
    hrdata = 32'h1234_5678; hresp = err;
    @(negedge clk);
    chk("rd_c3_im_hready", im_hready, 1);
    chk("rd_c3_im_hrdata", im_hrdata, 32'h1234_5678);
    chk("rd_c3_im_hresp", im_hresp, err);
    chk("rd_c3_dm_hresp", dm_hresp, 0);
    if (err) begin
      chk("err_c3_dm_haddr", haddr, 32'hB000_0020);
      chk("err_c3_dm_htrans", htrans, 2'b10);
      chk("err_c3_dm_hready", dm_hready, 0);
    end
    cyc();
    hresp = 1'b0;
    @(negedge clk);
    if (err) begin
      chk("err_c4_dm_hready", dm_hready, 1);
      chk("err_c4_dm_hresp", dm_hresp, 0);
      chk("err_c4_hwdata", hwdata, 32'h5A5A_5A5A);
    end
    cyc();
    @(negedge clk);
    chk("rd_end_htrans", htrans, 2'b00);
  endtask

  // Transaction-level model state for random traffic.
  logic [36:0] q_im[$];
  logic [36:0] q_dm[$];
  bit          out_im, out_dm;
  int          owner;  // 0 none, 1 IM, 2 DM
  logic [31:0] cur_wd_im, cur_wd_dm, nxt_wd_im, nxt_wd_dm;
  logic        prev_hready;
  logic [31:0] prev_haddr;
  logic [1:0]  prev_htrans;

  task automatic rand_cycle(input bit gen);
    logic        rdy_im, rdy_dm;
    logic [31:0] exp_wd;
    logic [36:0] exp_aph;
    int          nxt_owner;
    @(posedge clk);
    #1;
    cur_wd_im = nxt_wd_im;
    cur_wd_dm = nxt_wd_dm;
    hready = gen ? ($urandom_range(3) != 0) : 1'b1;
    hresp  = hready && ($urandom_range(7) == 0);
    hrdata = $urandom;
    rdy_im = !out_im ? 1'b1 : ((owner == 1) ? hready : 1'b0);
    rdy_dm = !out_dm ? 1'b1 : ((owner == 2) ? hready : 1'b0);
    im_hwdata = cur_wd_im;
    dm_hwdata = cur_wd_dm;
    im_htrans = gen ? 2'($urandom_range(3)) : 2'b00;
    dm_htrans = gen ? 2'($urandom_range(3)) : 2'b00;
    im_haddr  = {4'hA, 28'($urandom)};
    dm_haddr  = {4'hB, 28'($urandom)};
    im_hwrite = 1'($urandom); dm_hwrite = 1'($urandom);
    im_hprot  = 4'($urandom); dm_hprot  = 4'($urandom);
    @(negedge clk);
    chk("rnd_im_hready", im_hready, rdy_im);
    chk("rnd_dm_hready", dm_hready, rdy_dm);
    chk("rnd_im_hresp", im_hresp, (owner == 1) ? hresp : 1'b0);
    chk("rnd_dm_hresp", dm_hresp, (owner == 2) ? hresp : 1'b0);
    chk("rnd_im_hrdata", im_hrdata, hrdata);
    chk("rnd_dm_hrdata", dm_hrdata, hrdata);
    exp_wd = (owner == 1) ? cur_wd_im : ((owner == 2) ? cur_wd_dm : 32'h0);
    chk("rnd_hwdata", hwdata, exp_wd);
    chk("rnd_htrans_bit0", htrans[0], 0);
    if (!prev_hready) begin
      chk("rnd_stall_haddr", haddr, prev_haddr);
      chk("rnd_stall_htrans", htrans, prev_htrans);
    end
    nxt_owner = 0;
    if (hready && htrans == 2'b10) begin
      if (haddr[31:28] == 4'hA) begin
        chk("rnd_im_launch_pending", q_im.size(), 1);
        if (q_im.size() != 0) begin
          exp_aph = q_im.pop_front();
          chk("rnd_im_launch_aph", {haddr, hwrite, hprot}, exp_aph);
        end
        nxt_owner = 1;
      end else if (haddr[31:28] == 4'hB) begin
        chk("rnd_dm_launch_pending", q_dm.size(), 1);
        if (q_dm.size() != 0) begin
          exp_aph = q_dm.pop_front();
          chk("rnd_dm_launch_aph", {haddr, hwrite, hprot}, exp_aph);
        end
        nxt_owner = 2;
      end else begin
        chk("rnd_launch_tag", haddr[31:28], 4'hA);
      end
    end
    if (hready && owner == 1) out_im = 1'b0;
    if (hready && owner == 2) out_dm = 1'b0;
    if (rdy_im && im_htrans[1]) begin
      out_im = 1'b1;
      q_im.push_back({im_haddr, im_hwrite, im_hprot});
      nxt_wd_im = $urandom;
    end
    if (rdy_dm && dm_htrans[1]) begin
      out_dm = 1'b1;
      q_dm.push_back({dm_haddr, dm_hwrite, dm_hprot});
      nxt_wd_dm = $urandom;
    end
    if (hready) owner = nxt_owner;
    prev_hready = hready;
    prev_haddr  = haddr;
    prev_htrans = htrans;
  endtask

  initial begin
    rst = 1'b1;
    idle_masters();
    im_hwdata = 32'h1111_1111; dm_hwdata = 32'h2222_2222;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_haddr", haddr, 0);
    chk("rst_hwrite", hwrite, 0);
    chk("rst_hprot", hprot, 0);
    chk("rst_im_hready", im_hready, 1);
    chk("rst_dm_hready", dm_hready, 1);
    chk("rst_im_hresp", im_hresp, 0);
    chk("rst_dm_hresp", dm_hresp, 0);
    chk("rst_hwdata", hwdata, 0);
`ifdef ARB_PERF_CNT_EN
    chk("rst_contention_cnt", contention_cnt, 0);
`endif

    repeat (3) run_contention(1'b0);
`ifdef ARB_PERF_CNT_EN
    chk("perf_im_grant_cnt", im_grant_cnt, 3);
    chk("perf_dm_grant_cnt", dm_grant_cnt, 3);
    chk("perf_contention_cnt", contention_cnt, 3);
`endif
    run_contention(1'b1);
    run_im_read(1'b0);
    run_im_read(1'b1);

    // Reset in the middle of a stalled DM data phase.
    cyc();
    dm_htrans = 2'b10; dm_haddr = 32'hB000_0040; dm_hwrite = 1'b1;
    dm_hwdata = 32'h7777_7777;
    cyc(); idle_masters();
    cyc();
    @(negedge clk);
    chk("mid_c2_haddr", haddr, 32'hB000_0040);
    cyc();
    hready = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_htrans", htrans, 2'b00);
    chk("mid_rst_haddr", haddr, 0);
    chk("mid_rst_im_hready", im_hready, 1);
    chk("mid_rst_dm_hready", dm_hready, 1);
    chk("mid_rst_hwdata", hwdata, 0);
    cyc();
    rst = 1'b0; hready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_htrans", htrans, 2'b00);
      chk("post_rst_dm_hready", dm_hready, 1);
      cyc();
    end

    out_im = 1'b0; out_dm = 1'b0; owner = 0;
    cur_wd_im = '0; cur_wd_dm = '0; nxt_wd_im = 32'h0BAD_0001; nxt_wd_dm = 32'h0BAD_0002;
    prev_hready = 1'b1; prev_haddr = '0; prev_htrans = '0;
    for (int i = 0; i < 600; i++) rand_cycle(1'b1);
    for (int i = 0; i < 12; i++) rand_cycle(1'b0);
    chk("drain_im_outstanding", out_im, 0);
    chk("drain_dm_outstanding", out_dm, 0);
    chk("drain_im_queue", q_im.size(), 0);
    chk("drain_dm_queue", q_dm.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
Two-master to one-slave AHB-lite arbiter. It shares the single AHB slave port (ROM/RAM decode glue) between the instruction-fetch master (IM) and the data master (DM). Each master request is buffered in a one-entry hold register and launched onto a registered bus address phase. Bus data-phase ownership is tracked, so write data, ready, response and read data are steered to the correct master.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
DM_PRIORITY, 1, 1: DM wins when both masters are held; 0: IM wins
CNT_W, 32, performance counter width (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
im_haddr/dm_haddr  in  ADDR_W  master address
im_htrans/dm_htrans  in  2  master transfer type; bit1=1 means a request
im_hwrite/dm_hwrite  in  1  master write
im_hprot/dm_hprot  in  4  master protection
im_hwdata/dm_hwdata  in  DATA_W  master write data, driven in the data phase
im_hready/dm_hready  out  1  per-master ready
im_hresp/dm_hresp  out  1  per-master error response
im_hrdata/dm_hrdata  out  DATA_W  per-master read data
haddr  out  ADDR_W  bus address (registered)
htrans  out  2  bus transfer type: 2'b10 NONSEQ or 2'b00 IDLE (registered)
hwrite  out  1  bus write (registered)
hprot  out  4  bus protection (registered)
hwdata  out  DATA_W  bus write data, taken from the data-phase owner
hready  in  1  slave ready
hresp  in  1  slave error
hrdata  in  DATA_W  slave read data

Behaviour:
- Per-master FSM with states IDLE, HELD, APH, DPH.
- hready_x by state:
  - IDLE: 1.
  - HELD or APH: 0.
  - DPH: equals the bus hready.
- IDLE to HELD: when hready_x=1 and htrans_x[1]=1, capture {haddr, hwrite, hprot}.
- DPH completion: on hready=1 the transfer completes. The FSM goes to HELD if a new request is presented in the same cycle, otherwise IDLE.
- Bus slot advance happens on any edge with hready=1:
  - The APH owner moves to DPH and becomes the data-phase owner.
  - The arbitration winner among HELD masters moves to APH and loads the bus address registers with htrans=NONSEQ.
  - With no winner, the address registers load htrans=IDLE and the address is held.
  - SEQ requests are always issued as NONSEQ, because interleaving breaks bursts.
- Winner: the only HELD master. If both are HELD, DM wins when DM_PRIORITY=1, else IM.
- hready=0 freezes all bus registers, the owner and every FSM except the capture from IDLE.
- Data-phase steering:
  - hwdata is the data-phase owner's hwdata, or 0 when there is no owner.
  - The owner gets hresp and hready from the bus.
  - The non-owner's hresp is 0.
  - hrdata is broadcast to both masters.
- Latency, with zero slave wait states: request accepted in cycle 0, HELD in cycle 1, on the bus in cycle 2, data phase and hready_x=1 in cycle 3. Per-master throughput is 1 transfer per 3 cycles; the two masters interleave.
- Simultaneous events: both masters requesting in the same cycle are both captured. An error on the owner does not disturb the other master's HELD/APH state.
- Reset, including mid-transfer: all FSMs go to IDLE. haddr=0, htrans=2'b00, hwrite=0, hprot=0, no owner, hwdata=0. im_hready=dm_hready=1, hresp outputs 0. Any in-flight transfer is dropped.

Optional Feature:
- ARB_PERF_CNT_EN defined: adds outputs im_grant_cnt, dm_grant_cnt and contention_cnt, each CNT_W wide.
  - im_grant_cnt / dm_grant_cnt increment on each launch to APH for that master.
  - contention_cnt increments on each cycle where both masters are HELD.
  - All three wrap at 2^CNT_W and reset to 0.
- ARB_PERF_CNT_EN undefined: these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package ahb_arb_pkg:
  - HTRANS_IDLE=2'b00 and HTRANS_NONSEQ=2'b10.
  - Master state enum {IDLE, HELD, APH, DPH}.
  - Owner enum {OWN_NONE, OWN_IM, OWN_DM}.
  - Packed struct for the address phase {addr, write, prot}.
- Sub-module ahb_arb_port: per-master hold register, FSM and hready_x generation. Instantiated twice; the top level holds arbitration, bus registers and data-phase steering.

Test Plan:
- Reset: assert rst mid-DM transfer -> next cycle htrans=2'b00, im_hready=dm_hready=1, hwdata=0; on release no stale transfer is issued.
- Single IM read of 0xA000_0010 in cycle 0 -> haddr=0xA000_0010 with htrans=2'b10 and hwrite=0 in cycle 2; im_hready=0 in cycles 1-2; im_hready=1 in cycle 3 with im_hrdata=hrdata.
- Contention: IM read 0xA000_0000 and DM write 0xB000_0004 with data 0xDEADBEEF, both in cycle 0, DM_PRIORITY=1 -> DM address in cycle 2, IM address in cycle 3, hwdata=0xDEADBEEF in cycle 3, dm_hready=1 in cycle 3, im_hready=1 in cycle 4.
- Wait states: hready=0 for 2 cycles during the DM data phase -> dm_hready=0 and haddr/htrans stable in those cycles; IM stays in HELD or APH; flow resumes when hready=1.
- Error: hresp=1 and hready=1 during the IM data phase -> im_hresp=1 and im_hready=1; dm_hresp=0; DM transfer unaffected.
- With ARB_PERF_CNT_EN: the contention scenario run 3 times -> im_grant_cnt=3, dm_grant_cnt=3, contention_cnt=3.
